// File: rtl/program_loader.sv
// program_loader: streams program bytes into instruction memory, then
// releases the processor core from reset and waits for it to finish.
// Optional feature: define BRACKET_CHECK_EN to enable loop-bracket balance
// checking (OP_OPEN / OP_CLOSE) during the load.
module program_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  OP_OPEN  = 8'h5B,
  parameter logic [7:0]  OP_CLOSE = 8'h5D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_reset,
  input  logic              core_done,
  output logic [ADDR_W:0]   prog_len,
  output logic              load_error,
  output logic              halted
);

  typedef enum logic [2:0] {LOAD, START, RUN, HALT, ERR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [7:0]          imem_wdata_q, imem_wdata_d;
  logic                load_error_q, load_error_d;

  logic accept;
  logic at_top;
  logic bracket_err;

  assign accept = in_valid && in_ready;
  // The byte about to be accepted lands in the last memory location.
  assign at_top = &prog_len_q[ADDR_W-1:0];

`ifdef BRACKET_CHECK_EN
  logic [ADDR_W:0] depth_q, depth_d;

  // Track loop nesting; flag an unmatched close or an unbalanced final byte.
  always_comb begin
    depth_d     = depth_q;
    bracket_err = 1'b0;
    if (accept) begin
      if (in_data == OP_OPEN) begin
        depth_d = depth_q + 1'b1;
      end else if (in_data == OP_CLOSE) begin
        if (depth_q == '0) bracket_err = 1'b1;
        else               depth_d = depth_q - 1'b1;
      end
      if (in_last && (depth_d != '0)) bracket_err = 1'b1;
    end
  end

  // Loop-depth register, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end
`else
  assign bracket_err = 1'b0;
`endif

  // Next-state and write-port logic for the load / run sequencer.
  always_comb begin
    state_d      = state_q;
    prog_len_d   = prog_len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    load_error_d = load_error_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = prog_len_q[ADDR_W-1:0];
          imem_wdata_d = in_data;
          prog_len_d   = prog_len_q + 1'b1;
          // The offending byte is still written; only the state changes.
          if ((at_top && !in_last) || bracket_err) begin
            state_d      = ERR;
            load_error_d = 1'b1;
          end else if (in_last) begin
            state_d = START;
          end
        end
      end
      START:   state_d = RUN;
      RUN:     if (core_done) state_d = HALT;
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = LOAD;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      prog_len_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_len_q   <= prog_len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign core_reset = (state_q != RUN);
  assign halted     = (state_q == HALT);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign prog_len   = prog_len_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (instantiated with ADDR_W=4 so the
// address-overflow case is short). Bracket checks follow BRACKET_CHECK_EN.
module tb_program_loader;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              core_reset;
  logic              core_done = 1'b0;
  logic [ADDR_W:0]   prog_len;
  logic              load_error;
  logic              halted;

  int vectors = 0;
  int miscompares = 0;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_done(core_done),
    .prog_len(prog_len), .load_error(load_error), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Offer one byte for one cycle; after the edge the write must be visible.
  task automatic send(input logic [7:0] d, input logic last, input int exp_addr, input string tag);
    in_valid = 1'b1; in_data = d; in_last = last;
    tick();
    check({tag, ".we"},   32'(imem_we), 32'd1);
    check({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
    check({tag, ".data"}, 32'(imem_wdata), 32'(d));
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while reset is still asserted.
    reset = 1'b1;
    tick(); tick();
    check("rst.prog_len", 32'(prog_len), 32'd0);
    check("rst.we", 32'(imem_we), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'd0);
    check("rst.wdata", 32'(imem_wdata), 32'd0);
    check("rst.load_error", 32'(load_error), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.core_reset", 32'(core_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Basic load 2B,5B,2D,5D then START for one cycle, then RUN.
    send(8'h2B, 1'b0, 0, "ld0");
    send(8'h5B, 1'b0, 1, "ld1");
    send(8'h2D, 1'b0, 2, "ld2");
    send(8'h5D, 1'b1, 3, "ld3");
    check("start.prog_len", 32'(prog_len), 32'd4);
    check("start.core_reset", 32'(core_reset), 32'd1);
    check("start.in_ready", 32'(in_ready), 32'd0);
    tick();
    check("run.core_reset", 32'(core_reset), 32'd0);
    check("run.we", 32'(imem_we), 32'd0);
    check("run.halted", 32'(halted), 32'd0);
    tick();
    check("run.hold", 32'(core_reset), 32'd0);

    // core_done in RUN -> HALT, then input is ignored.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.core_reset", 32'(core_reset), 32'd1);
    in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    check("halt.in_ready", 32'(in_ready), 32'd0);
    check("halt.we", 32'(imem_we), 32'd0);
    check("halt.prog_len", 32'(prog_len), 32'd4);
    check("halt.sticky", 32'(halted), 32'd1);

    // Gapped in_valid: only handshaken bytes written, contiguously.
    do_reset();
    core_done = 1'b1;   // ignored in LOAD
    send(8'hA1, 1'b0, 0, "gap0");
    core_done = 1'b0;
    tick();
    check("gap.idle_we", 32'(imem_we), 32'd0);
    check("gap.idle_len", 32'(prog_len), 32'd1);
    send(8'hB2, 1'b0, 1, "gap1");
    tick(); tick();
    check("gap.idle2_we", 32'(imem_we), 32'd0);
    send(8'hC3, 1'b1, 2, "gap2");
    check("gap.prog_len", 32'(prog_len), 32'd3);

    // Overflow: 16 bytes with in_last=0 at ADDR_W=4.
    do_reset();
    for (int i = 0; i < 15; i++) send(8'(8'h10 + i), 1'b0, i, "ovf");
    check("ovf.pre_err", 32'(load_error), 32'd0);
    send(8'hEE, 1'b0, 15, "ovf15");
    check("ovf.load_error", 32'(load_error), 32'd1);
    check("ovf.in_ready", 32'(in_ready), 32'd0);
    check("ovf.prog_len", 32'(prog_len), 32'd16);
    core_done = 1'b1; in_valid = 1'b1;
    tick(); tick();
    core_done = 1'b0; in_valid = 1'b0;
    check("err.we", 32'(imem_we), 32'd0);
    check("err.halted", 32'(halted), 32'd0);
    check("err.core_reset", 32'(core_reset), 32'd1);
    check("err.prog_len", 32'(prog_len), 32'd16);

    // Reset mid-load, then reload two bytes from address 0.
    do_reset();
    send(8'h01, 1'b0, 0, "abt0");
    send(8'h02, 1'b0, 1, "abt1");
    send(8'h03, 1'b0, 2, "abt2");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abt.prog_len", 32'(prog_len), 32'd0);
    check("abt.in_ready", 32'(in_ready), 32'd1);
    send(8'h44, 1'b0, 0, "rl0");
    send(8'h55, 1'b1, 1, "rl1");
    check("rl.prog_len", 32'(prog_len), 32'd2);

    // Bracket behaviour: unmatched close, then unbalanced last byte.
    do_reset();
    send(8'h5D, 1'b0, 0, "br0");
`ifdef BRACKET_CHECK_EN
    check("br.close_err", 32'(load_error), 32'd1);
    check("br.close_ready", 32'(in_ready), 32'd0);
`else
    check("br.close_noerr", 32'(load_error), 32'd0);
    send(8'h2B, 1'b0, 1, "br1");
    check("br.unchecked_len", 32'(prog_len), 32'd2);
`endif
    do_reset();
    send(8'h5B, 1'b1, 0, "br2");
    tick();
`ifdef BRACKET_CHECK_EN
    check("br.open_err", 32'(load_error), 32'd1);
    check("br.no_start", 32'(core_reset), 32'd1);
`else
    check("br.open_noerr", 32'(load_error), 32'd0);
    check("br.run", 32'(core_reset), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 The block SHALL have parameter OP_OPEN, default 8'h5B, loop-open opcode byte.
REQ-003 The block SHALL have parameter OP_CLOSE, default 8'h5D, loop-close opcode byte.
REQ-004 The block SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid  input  1  a program byte is offered.
REQ-007 The block SHALL have port in_data  input  8  the program byte.
REQ-008 The block SHALL have port in_last  input  1  the offered byte is the final program byte.
REQ-009 The block SHALL have port in_ready  output  1  the loader accepts the byte this cycle.
REQ-010 The block SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-011 The block SHALL have port imem_addr  output  ADDR_W  instruction-memory write address.
REQ-012 The block SHALL have port imem_wdata  output  8  instruction-memory write data.
REQ-013 The block SHALL have port core_reset  output  1  holds the processor core in reset.
REQ-014 The block SHALL have port core_done  input  1  done flag from the processor core.
REQ-015 The block SHALL have port prog_len  output  ADDR_W+1  count of accepted bytes.
REQ-016 The block SHALL have port load_error  output  1  sticky load-failure flag.
REQ-017 The block SHALL have port halted  output  1  the core has finished running.

Function
REQ-018 The block SHALL implement FSM states LOAD, START, RUN, HALT and ERR.
REQ-019 A byte SHALL be accepted when in_valid and in_ready are both high; in_ready SHALL be high only in LOAD.
REQ-020 Each accepted byte SHALL produce, on the next cycle only, imem_we=1, imem_addr=prior prog_len[ADDR_W-1:0] and imem_wdata=that byte (one-cycle latency); otherwise imem_we SHALL be 0.
REQ-021 prog_len SHALL increment by 1 per accepted byte and never wrap.
REQ-022 An accepted byte with in_last=1 and no error SHALL move the FSM LOAD->START.
REQ-023 If the byte accepted at address 2^ADDR_W-1 has in_last=0, the FSM SHALL enter ERR and set load_error; that byte SHALL still be written.
REQ-024 START SHALL last exactly one cycle, with core_reset=1; it SHALL then move to RUN.
REQ-025 core_reset SHALL be 1 in LOAD, START, HALT and ERR, and 0 only in RUN.
REQ-026 In RUN, core_done=1 SHALL move the FSM to HALT on the next edge; core_done SHALL be ignored in every other state.
REQ-027 halted SHALL be 1 only in HALT; HALT and ERR SHALL be held until reset.
REQ-028 in_valid while in_ready=0 SHALL be ignored, with no write and no state change.

Reset
REQ-029 While reset is high at an edge, the FSM SHALL go to LOAD, with prog_len=0, loop depth=0, imem_we=0, imem_addr=0, imem_wdata=0, load_error=0, halted=0 and core_reset=1.
REQ-030 Reset asserted in any state, including mid-load or RUN, SHALL abort the operation; bytes already written SHALL be left in memory but not counted.
REQ-031 in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-032 When macro BRACKET_CHECK_EN is defined, an ADDR_W+1-bit loop-depth counter SHALL count +1 per accepted OP_OPEN byte and -1 per accepted OP_CLOSE byte.
REQ-033 With BRACKET_CHECK_EN, an OP_CLOSE accepted at depth 0 SHALL cause ERR, and an in_last byte that leaves depth nonzero SHALL cause ERR instead of START.
REQ-034 With BRACKET_CHECK_EN, the offending byte SHALL still be written.
REQ-035 When BRACKET_CHECK_EN is not defined, no depth counter SHALL exist, load_error SHALL be raised only by REQ-023, and bytes SHALL be written unchecked.

Verification
REQ-036 Bench SHALL cover: program bytes 2B,5B,2D,5D with in_last on the 4th -> writes at addresses 0..3 on cycles after acceptance; prog_len=4; START for 1 cycle; then core_reset=0.
REQ-037 Bench SHALL cover: in RUN, pulse core_done -> next cycle halted=1 and core_reset=1; further in_valid is ignored with in_ready=0.
REQ-038 Bench SHALL cover: in_valid toggled with gaps during load -> only handshaken bytes written, at contiguous addresses.
REQ-039 Bench SHALL cover: ADDR_W=4, 16 bytes with in_last=0 -> 16th byte written at address 15, then load_error=1 and the FSM in ERR.
REQ-040 Bench SHALL cover, with BRACKET_CHECK_EN: bytes 5D then 2B -> load_error=1 after the first byte; in a separate run, 5B with in_last -> load_error=1 and no START.
REQ-041 Bench SHALL cover: reset pulsed after 3 bytes, then reload 2 bytes -> prog_len=2 and writes at addresses 0 and 1.
